// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit with architectural HI/LO registers.
//
// Multiplies and divides run for a fixed latency (MULT_CYCLES / DIV_CYCLES).
// The result is computed when the request is accepted, held internally while
// busy is high, and written to HI/LO on the edge where busy falls.
// mthi/mtlo write HI/LO directly in a single edge without going busy.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   reset   in   asynchronous active-high reset
//   start   in   request strobe, sampled on the rising edge
//   op      in   0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6/7=no-op
//   A       in   rs operand (multiplicand / dividend / mthi-mtlo source)
//   B       in   rt operand (multiplier / divisor)
//   cancel  in   flush; aborts an in-flight operation, drops a start
//   busy    out  registered, high while an operation is in flight
//   HI, LO  out  registered HI/LO registers
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;

    // ---------------------------------------------------------------
    // Datapath: result of the operation presented on the inputs
    // ---------------------------------------------------------------
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               div_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag, uq, ur, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
        b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
        a_zx   = {{WIDTH{1'b0}}, A};
        b_zx   = {{WIDTH{1'b0}}, B};
        // Low 2*WIDTH bits of the extended product are the exact product.
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;

        // One unsigned divider serves both div and divu: signed division is
        // done on magnitudes and the signs are restored afterwards. This also
        // yields LO=A, HI=0 for most-negative / -1 without a special case,
        // since the negated magnitude wraps back to the most-negative value.
        div_signed = (op == OP_DIV);
        a_neg      = div_signed && A[WIDTH-1];
        b_neg      = div_signed && B[WIDTH-1];
        b_zero     = (B == '0);
        dvd_mag    = a_neg ? (~A + 1'b1) : A;
        dvs_mag    = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (b_neg ? (~B + 1'b1) : B);
        uq         = dvd_mag / dvs_mag;
        ur         = dvd_mag % dvs_mag;
        quo        = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
        rem        = a_neg ? (~ur + 1'b1) : ur;

        res_hi = '0;
        res_lo = '0;
        case (op)
            OP_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b_zero) begin
                    res_hi = A;
                    res_lo = '1;
                end else begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Control: IDLE/RUN with latency down-counter
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = MULT_N;
                            state_d   = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = DIV_N;
                            state_d   = ST_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed and randomized checks of md_unit (WIDTH=32,
// MULT_CYCLES=5, DIV_CYCLES=10) against a 64-bit arithmetic reference.
module tb_md_unit;

    localparam int W    = 32;
    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd7;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          cancel = 1'b0;
    logic          busy;
    logic [W-1:0]  HI, LO;

    int total = 0;
    int bad   = 0;

    // Reference HI/LO state
    logic [W-1:0]  hi_m = '0;
    logic [W-1:0]  lo_m = '0;

    md_unit #(
        .WIDTH(W),
        .MULT_CYCLES(MULN),
        .DIV_CYCLES(DIVN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .A(A),
        .B(B),
        .cancel(cancel),
        .busy(busy),
        .HI(HI),
        .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO become after a completed op 0..3
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint          sp, sa, sb, q, r;
        longint unsigned up;
        rh = hi_m;
        rl = lo_m;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                rh = sp[63:32];
                rl = sp[31:0];
            end
            3'd1: begin
                up = longint'({32'b0, a}) * longint'({32'b0, b});
                rh = up[63:32];
                rl = up[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    rh = a; rl = '1;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    rh = r[31:0];
                    rl = q[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    rh = a; rl = '1;
                end else begin
                    rh = a % b;
                    rl = a / b;
                end
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge after the op
    // completes (or right after the accepting edge for single-edge ops).
    // noise=1 drives random ignored requests on every busy cycle.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input string tag);
        logic [W-1:0] eh, el;
        int n;
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        if (o <= 3'd3) begin
            n = (o <= 3'd1) ? MULN : DIVN;
            model(o, a, b, eh, el);
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge clk);
                chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
                chk({tag, ".hi_hold"}, HI, hi_m);
                chk({tag, ".lo_hold"}, LO, lo_m);
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    op    = 3'($urandom_range(0, 7));
                    A     = $urandom;
                    B     = $urandom;
                end
            end
            @(negedge clk);
            start = 1'b0;
            hi_m = eh;
            lo_m = el;
        end else if (o == 3'd4) begin
            hi_m = a;
        end else if (o == 3'd5) begin
            lo_m = a;
        end
        chk({tag, ".busy_done"}, {31'b0, busy}, 32'd0);
        chk({tag, ".hi"}, HI, hi_m);
        chk({tag, ".lo"}, LO, lo_m);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #2;
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.hi", HI, 32'd0);
        chk("reset.lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 1'b0, "mult");
        chk("mult.hi_const", HI, 32'hFFFFFFFF);
        chk("mult.lo_const", LO, 32'hFFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, "multu");
        chk("multu.hi_const", HI, 32'h00000001);
        chk("multu.lo_const", LO, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, "div");
        chk("div.lo_const", LO, 32'hFFFFFFFD);
        chk("div.hi_const", HI, 32'hFFFFFFFF);
        run_op(3'd3, 32'd7, 32'd2, 1'b0, "divu");
        chk("divu.lo_const", LO, 32'd3);
        chk("divu.hi_const", HI, 32'd1);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        chk("div_ovf.lo_const", LO, 32'h80000000);
        chk("div_ovf.hi_const", HI, 32'h00000000);
        run_op(3'd3, 32'd5, 32'd0, 1'b0, "divu0");
        chk("divu0.hi_const", HI, 32'h00000005);
        chk("divu0.lo_const", LO, 32'hFFFFFFFF);
        run_op(3'd2, 32'hFFFFFF00, 32'd0, 1'b0, "div0");

        // mthi while busy is ignored, then accepted once idle
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_busy.hi", HI, hi_m);
        chk("mthi_busy.busy", {31'b0, busy}, 32'd1);
        repeat (MULN - 1) @(negedge clk);
        hi_m = 32'd0; lo_m = 32'd12;
        chk("mthi_busy.done_hi", HI, hi_m);
        chk("mthi_busy.done_lo", LO, lo_m);
        run_op(3'd4, 32'h12345678, 32'd0, 1'b0, "mthi");
        chk("mthi.hi_const", HI, 32'h12345678);
        run_op(3'd5, 32'hCAFEF00D, 32'd0, 1'b0, "mtlo");

        // Cancel on the third busy cycle
        start = 1'b1; op = 3'd0; A = 32'd100; B = 32'd200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cancel.busy3", {31'b0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel.busy", {31'b0, busy}, 32'd0);
        repeat (MULN + 2) @(negedge clk);
        chk("cancel.hi", HI, hi_m);
        chk("cancel.lo", LO, lo_m);
        chk("cancel.busy_later", {31'b0, busy}, 32'd0);

        // Start with cancel in IDLE is dropped, for both a run op and mthi
        start = 1'b1; cancel = 1'b1; op = 3'd2; A = 32'd9; B = 32'd3;
        @(negedge clk);
        chk("drop_div.busy", {31'b0, busy}, 32'd0);
        op = 3'd4;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("drop_mthi.hi", HI, hi_m);

        // No-op codes
        run_op(3'd6, 32'hDEADBEEF, 32'd1, 1'b0, "nop6");
        run_op(3'd7, 32'hDEADBEEF, 32'd1, 1'b0, "nop7");

        // Randomized, back-to-back, with ignored requests while busy
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            run_op(ro, ra, rb, 1'b1, "rand");
        end

        // Reset mid-divide, between clock edges
        start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.busy", {31'b0, busy}, 32'd0);
        chk("rst_mid.hi", HI, 32'd0);
        chk("rst_mid.lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (DIVN + 2) @(negedge clk);
        chk("rst_after.busy", {31'b0, busy}, 32'd0);
        chk("rst_after.hi", HI, 32'd0);
        chk("rst_after.lo", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, multiply latency in cycles (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, divide latency in cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; operation is sampled on the rising edge where start=1.
REQ-007 SHALL have port op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=no-op.
REQ-008 SHALL have port A  input  WIDTH  rs operand (dividend / mthi-mtlo source).
REQ-009 SHALL have port B  input  WIDTH  rt operand (divisor).
REQ-010 SHALL have port cancel  input  1  pipeline flush; aborts in-flight operation.
REQ-011 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-012 SHALL have port HI  output  WIDTH  registered HI register.
REQ-013 SHALL have port LO  output  WIDTH  registered LO register.

Function
REQ-014 SHALL be a two-state machine: IDLE (busy=0) and RUN (busy=1) with a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 SHALL, in IDLE with start=1, cancel=0 and op in 0..3, capture the result, load the counter with the op's latency and enter RUN on that edge.
REQ-016 SHALL hold busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) after the accepting edge; HI/LO update on the same edge on which busy falls.
REQ-017 SHALL leave HI/LO unchanged throughout RUN until completion; in-flight result stays internal.
REQ-018 SHALL, for mult/multu, produce the 2*WIDTH signed/unsigned product; HI=upper WIDTH bits, LO=lower WIDTH bits.
REQ-019 SHALL, for div/divu, set LO=quotient truncated toward zero and HI=remainder carrying the dividend's sign (div) or unsigned (divu).
REQ-020 SHALL, on divisor 0 (div or divu), set HI=A and LO=all ones after DIV_CYCLES.
REQ-021 SHALL, for div with A=most-negative and B=-1, set LO=A and HI=0.
REQ-022 SHALL, in IDLE with start=1, cancel=0 and op=4/5, write A to HI/LO on that edge with busy staying 0.
REQ-023 SHALL ignore start (any op, including mthi/mtlo) while in RUN; the pipeline stalls on start|busy externally.
REQ-024 SHALL ignore op 6/7 with no state change.
REQ-025 SHALL, on cancel=1 in RUN, return to IDLE on that edge with busy=0 and HI/LO unchanged.
REQ-026 SHALL give cancel priority over start: start with cancel=1 is dropped, in either state.
REQ-027 SHALL accept a new start on the edge after busy falls (back-to-back, no dead cycle beyond IDLE).

Reset
REQ-028 SHALL, on reset=1, immediately force IDLE, busy=0, counter=0, HI=0, LO=0, independent of clk.
REQ-029 SHALL discard any in-flight operation when reset asserts mid-RUN; no HI/LO update follows.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-030 SHALL cover mult A=FFFFFFFF, B=00000002 -> busy high 5 cycles, then HI=FFFFFFFF, LO=FFFFFFFE; multu same operands -> HI=00000001, LO=FFFFFFFE.
REQ-031 SHALL cover div A=FFFFFFF9, B=00000002 -> after 10 cycles LO=FFFFFFFD, HI=FFFFFFFF; divu A=7, B=2 -> LO=3, HI=1; div A=80000000, B=FFFFFFFF -> LO=80000000, HI=0.
REQ-032 SHALL cover divu A=00000005, B=0 -> HI=00000005, LO=FFFFFFFF after 10 cycles.
REQ-033 SHALL cover mthi A=12345678 while busy -> ignored, HI unchanged; repeated after busy falls -> HI=12345678 on that edge, busy stays 0.
REQ-034 SHALL cover mult start then cancel on 3rd busy cycle -> busy=0 next edge, HI/LO keep prior values, no later update.
REQ-035 SHALL cover reset asserted mid-div between clock edges -> busy, HI, LO go to 0 immediately and stay 0 after reset release.
